// File: rtl/dac_thermo_sched_pkg.sv
// Shared types and helpers for the DAC thermometer sequencer.
//   state_t   : sequencer FSM states (IDLE, SETTLE)
//   ptr_t     : DWA pointer type for the default 256-cell array
//   ptr_width : pointer width for an arbitrary cell count
package dac_sched_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    localparam int unsigned DEF_IN_WIDTH = 256;
    localparam int unsigned DEF_PTR_W    = $clog2(DEF_IN_WIDTH);

    typedef logic [DEF_PTR_W-1:0] ptr_t;

    // A single-cell array still needs a 1-bit pointer port.
    function automatic int unsigned ptr_width(input int unsigned in_width);
        return (in_width > 1) ? $clog2(in_width) : 1;
    endfunction

endpackage

// File: rtl/dac_thermo_sched_if.sv
// Sample-code handshake between the code source and the sequencer.
//   code     : requested number of active cells
//   in_valid : code valid
//   in_ready : sequencer can accept a code this cycle
interface dac_thermo_sched_if #(
    parameter int CODE_WIDTH = 9
);
    logic [CODE_WIDTH-1:0] code;
    logic                  in_valid;
    logic                  in_ready;

    modport master (output code, output in_valid, input in_ready);
    modport slave  (input code, input in_valid, output in_ready);
endinterface

// File: rtl/dac_thermo_sched_dwa_mask.sv
// Combinational rotated thermometer mask.
//   ptr  : start cell of the active run
//   c    : number of active cells, 0..IN_WIDTH (already clamped)
//   mask : mask[i] = 1 iff ((i - ptr) mod IN_WIDTH) < c
module dwa_mask #(
    parameter int IN_WIDTH   = 256,
    parameter int CODE_WIDTH = 9,
    parameter int PTR_WIDTH  = 8
) (
    input  logic [PTR_WIDTH-1:0]  ptr,
    input  logic [CODE_WIDTH-1:0] c,
    output logic [IN_WIDTH-1:0]   mask
);

    logic [IN_WIDTH-1:0]   base_s;
    logic [2*IN_WIDTH-1:0] dbl_s;

    // Unrotated thermometer: the lowest c cells set.
    always_comb begin
        base_s = {IN_WIDTH{1'b0}};
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (i < int'(c)) begin
                base_s[i] = 1'b1;
            end else begin
                base_s[i] = 1'b0;
            end
        end
    end

    // Rotate left by ptr: shifting a doubled copy makes the wrapped bits
    // land in the upper half, which is the rotated result.
    always_comb begin
        dbl_s = {base_s, base_s} << ptr;
        mask  = dbl_s[2*IN_WIDTH-1:IN_WIDTH];
    end

endmodule

// File: rtl/dac_thermo_sched.sv
// Sequencer feeding the per-cell non-overlap stage of the current-steering
// DAC. Accepts binary codes, converts them to a (optionally DWA-rotated)
// unit-cell enable vector and then blocks new codes for SETTLE_CYCLES.
//   clk, rst : clock, synchronous active-high reset
//   bus      : code / in_valid / in_ready handshake (slave side)
//   clear    : synchronous mute, zeroes outputs and pointer
//   thermo   : registered cell enables
//   ptr      : current DWA start pointer
//   busy     : high while settling
//   sat      : one-cycle pulse when an accepted code exceeded IN_WIDTH
module dac_thermo_sched
    import dac_sched_pkg::*;
#(
    parameter  int IN_WIDTH      = 256,
    parameter  int CODE_WIDTH    = $clog2(IN_WIDTH + 1),
    parameter  int SETTLE_CYCLES = 4,
    parameter  int DWA_EN        = 1,
    localparam int PTR_WIDTH     = ptr_width(IN_WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    dac_thermo_sched_if.slave         bus,
    input  logic                      clear,
    output logic [IN_WIDTH-1:0]       thermo,
    output logic [PTR_WIDTH-1:0]      ptr,
    output logic                      busy,
    output logic                      sat
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : {CNT_W{1'b0}};

    state_t                 state_r;
    state_t                 state_nx_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [IN_WIDTH-1:0]    thermo_r;
    logic [PTR_WIDTH-1:0]   ptr_r;
    logic                   busy_r;
    logic                   sat_r;

    logic                   in_ready_s;
    logic                   xfer_s;
    logic                   sat_nx_s;
    logic [CODE_WIDTH-1:0]  c_s;
    logic [PTR_WIDTH-1:0]   ptr_nx_s;
    logic [IN_WIDTH-1:0]    mask_s;

    // Clamp the requested code to the number of cells and flag overflow.
    always_comb begin
        sat_nx_s = (bus.code > CODE_WIDTH'(IN_WIDTH));
        if (sat_nx_s) begin
            c_s = CODE_WIDTH'(IN_WIDTH);
        end else begin
            c_s = bus.code;
        end
    end

    // Truncated add: c == IN_WIDTH contributes 0 modulo the cell count.
    always_comb begin
        ptr_nx_s = ptr_r + c_s[PTR_WIDTH-1:0];
    end

    dwa_mask #(
        .IN_WIDTH   (IN_WIDTH),
        .CODE_WIDTH (CODE_WIDTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_dwa_mask (
        .ptr  (ptr_r),
        .c    (c_s),
        .mask (mask_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; clear forces IDLE from any state.
    always_comb begin
        state_nx_s = state_r;
        if (clear) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (xfer_s && (SETTLE_CYCLES != 0)) begin
                        state_nx_s = SETTLE;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                SETTLE: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_nx_s = IDLE;
                    end else begin
                        state_nx_s = SETTLE;
                    end
                end
                default: state_nx_s = IDLE;
            endcase
        end
    end

    // FSM output decode: ready only in IDLE, masked by clear and reset.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            IDLE:    in_ready_s = ~clear & ~rst;
            SETTLE:  in_ready_s = 1'b0;
            default: in_ready_s = 1'b0;
        endcase
    end

    assign bus.in_ready = in_ready_s;
    assign xfer_s       = bus.in_valid & in_ready_s;

    // Settle counter: loaded on transfer, counts down to 0 in SETTLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (xfer_s) begin
            cnt_r <= CNT_LOAD;
        end else if ((state_r == SETTLE) && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Output registers: cell enables, pointer, saturation pulse, busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            thermo_r <= {IN_WIDTH{1'b0}};
            ptr_r    <= {PTR_WIDTH{1'b0}};
            sat_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else if (clear) begin
            thermo_r <= {IN_WIDTH{1'b0}};
            ptr_r    <= {PTR_WIDTH{1'b0}};
            sat_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else if (xfer_s) begin
            thermo_r <= mask_s;
            if (DWA_EN != 0) begin
                ptr_r <= ptr_nx_s;
            end else begin
                ptr_r <= {PTR_WIDTH{1'b0}};
            end
            sat_r    <= sat_nx_s;
            busy_r   <= (state_nx_s == SETTLE);
        end else begin
            thermo_r <= thermo_r;
            ptr_r    <= ptr_r;
            sat_r    <= 1'b0;
            busy_r   <= (state_nx_s == SETTLE);
        end
    end

    assign thermo = thermo_r;
    assign ptr    = ptr_r;
    assign busy   = busy_r;
    assign sat    = sat_r;

endmodule

// File: tb/tb_dac_thermo_sched.sv
// Self-checking bench for dac_thermo_sched (16 cells, 2 settle cycles).
// A DWA instance is checked against a behavioural model every cycle; a
// second instance with DWA disabled is checked with directed constants.
module tb_dac_thermo_sched;

    localparam int N  = 16;
    localparam int S  = 2;
    localparam int CW = 5;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          clear0;
    logic [N-1:0]  thermo, thermo0;
    logic [PW-1:0] ptr, ptr0;
    logic          busy, busy0, sat, sat0;

    dac_thermo_sched_if #(.CODE_WIDTH(CW)) bus  ();
    dac_thermo_sched_if #(.CODE_WIDTH(CW)) bus0 ();

    always #5 clk = ~clk;

    dac_thermo_sched #(
        .IN_WIDTH(N), .SETTLE_CYCLES(S), .DWA_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .clear(clear),
        .thermo(thermo), .ptr(ptr), .busy(busy), .sat(sat)
    );

    dac_thermo_sched #(
        .IN_WIDTH(N), .SETTLE_CYCLES(S), .DWA_EN(0)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .clear(clear0),
        .thermo(thermo0), .ptr(ptr0), .busy(busy0), .sat(sat0)
    );

    // Reference model: cycles of settle still owed, pointer, cells, sat.
    int          m_rem   = 0;
    int          m_ptr   = 0;
    logic [N-1:0] m_thermo = '0;
    logic        m_sat   = 1'b0;

    int   total = 0;
    int   bad   = 0;
    logic last_rdy;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Apply one rising edge worth of the specification's rules.
    task automatic model_edge(input logic r, input logic cl, input logic v, input logic [CW-1:0] cd);
        int c;
        if (r || cl) begin
            m_rem = 0; m_ptr = 0; m_thermo = '0; m_sat = 1'b0;
        end else begin
            m_sat = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
            end else if (v) begin
                c = (int'(cd) > N) ? N : int'(cd);
                for (int i = 0; i < N; i++)
                    m_thermo[i] = (((i - m_ptr + N) % N) < c);
                m_ptr = (m_ptr + c) % N;
                m_sat = (int'(cd) > N);
                m_rem = S;
            end
        end
    endtask

    // One clock: check ready before the edge, then registered outputs after.
    task automatic tick();
        logic r, cl, v, exp_rdy;
        logic [CW-1:0] cd;
        #1;
        exp_rdy  = (m_rem == 0) && !clear && !rst;
        last_rdy = bus.in_ready;
        chk("in_ready", bus.in_ready, exp_rdy);
        r = rst; cl = clear; v = bus.in_valid; cd = bus.code;
        @(posedge clk);
        #1;
        model_edge(r, cl, v, cd);
        chk("thermo", thermo, m_thermo);
        chk("ptr",    ptr,    m_ptr);
        chk("busy",   busy,   (m_rem > 0));
        chk("sat",    sat,    m_sat);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        #1;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("ready_timeout", (n < 20), 1);
    endtask

    task automatic send(input logic [CW-1:0] cd);
        bus.code     = cd;
        bus.in_valid = 1'b1;
        wait_ready();
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [8:0] pattern;
        logic       hold;
        rst = 1'b1; clear = 1'b0; clear0 = 1'b0;
        bus.code = '0;  bus.in_valid = 1'b0;
        bus0.code = '0; bus0.in_valid = 1'b0;

        // Reset
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_thermo", thermo, 16'h0000);
        chk("rst_ptr",    ptr,    0);
        chk("rst_busy",   busy,   0);
        #1;
        chk("rst_ready",  bus.in_ready, 1);

        // Plain thermometer instance: codes 5 then 13, pointer pinned at 0
        bus0.code = 5'd5; bus0.in_valid = 1'b1;
        chk("nodwa_ready0", bus0.in_ready, 1);
        tick();
        bus0.in_valid = 1'b0;
        chk("nodwa_t5", thermo0, 16'h001F);
        chk("nodwa_p5", ptr0, 0);
        repeat (2) tick();
        bus0.code = 5'd13; bus0.in_valid = 1'b1;
        #1;
        chk("nodwa_ready1", bus0.in_ready, 1);
        tick();
        bus0.in_valid = 1'b0;
        chk("nodwa_t13", thermo0, 16'h1FFF);
        chk("nodwa_p13", ptr0, 0);

        // Rotation and wrap-around
        send(5'd5);
        chk("rot_t5", thermo, 16'h001F);
        chk("rot_p5", ptr, 5);
        send(5'd13);
        chk("rot_t13", thermo, 16'hFFE3);
        chk("rot_p13", ptr, 2);

        // Full scale and saturation
        send(5'd16);
        chk("full_t", thermo, 16'hFFFF);
        chk("full_p", ptr, 2);
        chk("full_sat", sat, 0);
        send(5'd20);
        chk("sat_t", thermo, 16'hFFFF);
        chk("sat_p", ptr, 2);
        chk("sat_hi", sat, 1);
        tick();
        chk("sat_lo", sat, 0);

        // Settle spacing with in_valid held high
        wait_ready();
        bus.code = 5'd3; bus.in_valid = 1'b1;
        pattern = '0;
        for (int i = 0; i < 9; i++) begin
            tick();
            pattern[i] = last_rdy;
        end
        bus.in_valid = 1'b0;
        chk("spacing", pattern, 9'b001001001);

        // clear colliding with a transfer in IDLE
        wait_ready();
        clear = 1'b1; bus.code = 5'd7; bus.in_valid = 1'b1;
        #1;
        chk("clr_ready", bus.in_ready, 0);
        tick();
        clear = 1'b0; bus.in_valid = 1'b0;
        chk("clr_thermo", thermo, 16'h0000);
        chk("clr_ptr", ptr, 0);

        // clear in the middle of settling
        send(5'd4);
        chk("mid_busy0", busy, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("mid_busy1", busy, 0);
        chk("mid_thermo", thermo, 16'h0000);
        #1;
        chk("mid_ready", bus.in_ready, 1);

        // Randomized traffic with occasional clear and reset
        hold = 1'b0;
        for (int k = 0; k < 400; k++) begin
            rst   = ($urandom_range(63) == 0);
            clear = ($urandom_range(15) == 0);
            if (!hold) begin
                bus.code = ($urandom_range(3) == 0) ? CW'($urandom_range(31))
                                                    : CW'($urandom_range(16));
                bus.in_valid = ($urandom_range(1) == 1);
            end
            tick();
            // A pending request must keep its code until it is taken.
            hold = bus.in_valid && !last_rdy && ($urandom_range(3) != 0);
        end
        rst = 1'b0; clear = 1'b0; bus.in_valid = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
